// File: rtl/lcd_pkg.sv
// lcd_pkg: HD44780 command/character constants, writer FSM states and the digit-to-ASCII map.
package lcd_pkg;
  localparam logic [7:0] CMD_FSET_8B2L = 8'h38;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
  localparam logic [7:0] CMD_DDRAM_L1  = 8'h80;
  localparam logic [7:0] CHAR_SEP      = 8'h3A;
  localparam logic [7:0] CHAR_SPACE    = 8'h20;
  localparam logic [7:0] CHAR_ZERO     = 8'h30;
  localparam logic [3:0] LAST_COL      = 4'd10;
  typedef enum logic [2:0] {
    PWR_WAIT, INIT_FSET, INIT_DISP, INIT_CLR, INIT_ENTRY, FRAME_ADDR, FRAME_CHAR
  } state_e;
  function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
    return (d < 4'd10) ? CHAR_ZERO + {4'h0, d} : (d == 4'd10) ? CHAR_SEP : CHAR_SPACE;
  endfunction
endpackage

// File: rtl/lcd_num_writer_if.sv
// lcd_num_writer_if: HD44780 8-bit parallel write bus.
interface lcd_num_writer_if;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  modport master (output lcd_data, lcd_rs, lcd_rw, lcd_e);
  modport slave (input lcd_data, lcd_rs, lcd_rw, lcd_e);
endinterface

// File: rtl/lcd_byte_strobe.sv
// lcd_byte_strobe: one LCD byte write as setup cycle, E pulse, then a short or long settle wait.
module lcd_byte_strobe #(
  parameter int E_PULSE_CYC    = 25,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLEAR_WAIT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [7:0] byte_i,
  input  logic       long_wait_i,
  output logic       done_o,
  output logic       lcd_rs_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_e_o
);
  localparam int MAX_WAIT = (CMD_WAIT_CYC > CLEAR_WAIT_CYC) ? CMD_WAIT_CYC : CLEAR_WAIT_CYC;
  localparam int CW = $clog2(E_PULSE_CYC + MAX_WAIT + 1);
  localparam logic [CW-1:0] E_LAST = CW'(E_PULSE_CYC);
  localparam logic [CW-1:0] LAST_S = CW'(E_PULSE_CYC + CMD_WAIT_CYC);
  localparam logic [CW-1:0] LAST_L = CW'(E_PULSE_CYC + CLEAR_WAIT_CYC);
  logic          busy_q, busy_d, long_q, long_d, rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign done_o     = busy_q && cnt_q == (long_q ? LAST_L : LAST_S);
  assign lcd_e_o    = busy_q && cnt_q != '0 && cnt_q <= E_LAST;
  assign lcd_rs_o   = rs_q;
  assign lcd_data_o = data_q;
  // a start in the done cycle chains the next byte with no idle gap
  always_comb begin
    busy_d = start_i | (busy_q & ~done_o);
    cnt_d  = start_i ? '0 : busy_q ? cnt_q + 1'b1 : cnt_q;
    long_d = start_i ? long_wait_i : long_q;
    rs_d   = start_i ? rs_i : rs_q;
    data_d = start_i ? byte_i : data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      long_q <= 1'b0;
      rs_q   <= 1'b0;
      data_q <= 8'h00;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      long_q <= long_d;
      rs_q   <= rs_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/lcd_num_writer.sv
// lcd_num_writer: LCD init then endless refresh of line 1 cols 0-10 from a per-frame digit snapshot.
// Optional LCD_LEAD_ZERO_BLANK_EN blanks column 0 when its digit is 0.
module lcd_num_writer
  import lcd_pkg::*;
#(
  parameter int INIT_WAIT_CYC  = 750000,
  parameter int E_PULSE_CYC    = 25,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLEAR_WAIT_CYC = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [43:0]        num_data,
  lcd_num_writer_if.master   lcd,
  output logic               init_done,
  output logic               frame_done
);
  localparam int PW = $clog2(INIT_WAIT_CYC + 1);
  localparam logic [PW-1:0] PW_LAST = PW'(INIT_WAIT_CYC - 1);
  state_e        state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [3:0]    col_q, col_d, ncol;
  logic [43:0]   fb_q, fb_d;
  logic          init_done_q, init_done_d, frame_done_q, frame_done_d;
  logic          start, rs, long_wait, done, to_addr;
  logic [7:0]    byte_s, chr;
  logic [3:0]    nib;
  assign ncol = (state_q == FRAME_CHAR && col_q != LAST_COL) ? col_q + 4'd1 : 4'd0;
  assign nib  = fb_q[{ncol, 2'b00} +: 4];
`ifdef LCD_LEAD_ZERO_BLANK_EN
  assign chr = (ncol == 4'd0 && nib == 4'd0) ? CHAR_SPACE : digit_to_ascii(nib);
`else
  assign chr = digit_to_ascii(nib);
`endif
  assign to_addr    = done && (state_q == INIT_ENTRY || (state_q == FRAME_CHAR && col_q == LAST_COL));
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;
  assign lcd.lcd_rw = 1'b0;
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    col_d        = col_q;
    fb_d         = fb_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    start        = 1'b0;
    rs           = 1'b0;
    byte_s       = 8'h00;
    long_wait    = 1'b0;
    case (state_q)
      PWR_WAIT:   if (cnt_q == PW_LAST) begin start = 1'b1; byte_s = CMD_FSET_8B2L; state_d = INIT_FSET; end
                  else cnt_d = cnt_q + 1'b1;
      INIT_FSET:  if (done) begin start = 1'b1; byte_s = CMD_DISP_ON; state_d = INIT_DISP; end
      INIT_DISP:  if (done) begin start = 1'b1; byte_s = CMD_CLEAR; long_wait = 1'b1; state_d = INIT_CLR; end
      INIT_CLR:   if (done) begin start = 1'b1; byte_s = CMD_ENTRY_INC; state_d = INIT_ENTRY; end
      FRAME_ADDR, FRAME_CHAR:
                  if (done && !to_addr) begin start = 1'b1; rs = 1'b1; byte_s = chr; col_d = ncol; state_d = FRAME_CHAR; end
      default:    ;
    endcase
    // the snapshot is taken on the same edge that launches the address byte
    if (to_addr) begin
      start        = 1'b1;
      byte_s       = CMD_DDRAM_L1;
      state_d      = FRAME_ADDR;
      fb_d         = num_data;
      init_done_d  = 1'b1;
      frame_done_d = state_q == FRAME_CHAR;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= PWR_WAIT;
      cnt_q        <= '0;
      col_q        <= 4'd0;
      fb_q         <= '0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      col_q        <= col_d;
      fb_q         <= fb_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
    end
  end
  lcd_byte_strobe #(
    .E_PULSE_CYC(E_PULSE_CYC), .CMD_WAIT_CYC(CMD_WAIT_CYC), .CLEAR_WAIT_CYC(CLEAR_WAIT_CYC)
  ) u_strobe (
    .clk(clk), .rst(rst), .start_i(start), .rs_i(rs), .byte_i(byte_s), .long_wait_i(long_wait),
    .done_o(done), .lcd_rs_o(lcd.lcd_rs), .lcd_data_o(lcd.lcd_data), .lcd_e_o(lcd.lcd_e)
  );
endmodule

// File: tb/tb_lcd_num_writer.sv
// tb_lcd_num_writer: directed checks of init timing, frame bytes, snapshot coherency and mid-byte reset.
module tb_lcd_num_writer;
  localparam int INIT = 10, EP = 2, CMDW = 4, CLRW = 8;
  localparam int PER = 1 + EP + CMDW;
  localparam int PER_CLR = 1 + EP + CLRW;
`ifdef LCD_LEAD_ZERO_BLANK_EN
  localparam logic [7:0] E2_C0 = 8'h20;
`else
  localparam logic [7:0] E2_C0 = 8'h30;
`endif
  localparam logic [43:0] D1 = 44'h0005A95A213;
  localparam logic [43:0] D2 = 44'h64A87FEDCB0;
  localparam logic [43:0] D3 = 44'hA0987654321;
  localparam logic [7:0] E1 [11] = '{8'h33, 8'h31, 8'h32, 8'h3A, 8'h35, 8'h39, 8'h3A, 8'h35, 8'h30, 8'h30, 8'h30};
  localparam logic [7:0] E2 [11] = '{E2_C0, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h37, 8'h38, 8'h3A, 8'h34, 8'h36};
  localparam logic [7:0] E3 [11] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h30, 8'h3A};
  logic        clk = 1'b0, rst = 1'b1;
  logic [43:0] num_data = '0;
  logic        init_done, frame_done;
  int          cyc = 0, fd_total = 0, fd_cyc = -1;
  int          checks = 0, errors = 0;
  lcd_num_writer_if lcd_if ();
  lcd_num_writer #(
    .INIT_WAIT_CYC(INIT), .E_PULSE_CYC(EP), .CMD_WAIT_CYC(CMDW), .CLEAR_WAIT_CYC(CLRW)
  ) dut (
    .clk(clk), .rst(rst), .num_data(num_data), .lcd(lcd_if), .init_done(init_done), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frame_done === 1'b1) begin fd_total <= fd_total + 1; fd_cyc <= cyc; end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // called at a negedge; returns the cycle index of the first E-high sample
  task automatic wait_byte(input string tag, input logic exp_rs, input logic [7:0] exp_d, output int rise);
    logic pe, prs, found;
    logic [7:0] pd;
    int n, hi;
    pe = lcd_if.lcd_e; pd = lcd_if.lcd_data; prs = lcd_if.lcd_rs; n = 0; found = 1'b0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (lcd_if.lcd_e === 1'b1 && pe === 1'b0) begin found = 1'b1; break; end
      pe = lcd_if.lcd_e; pd = lcd_if.lcd_data; prs = lcd_if.lcd_rs;
    end
    rise = cyc;
    chk({tag, "_seen"}, {31'd0, found}, 32'd1);
    if (!found) return;
    chk({tag, "_data"}, {24'd0, lcd_if.lcd_data}, {24'd0, exp_d});
    chk({tag, "_rs"}, {31'd0, lcd_if.lcd_rs}, {31'd0, exp_rs});
    chk({tag, "_setup_data"}, {24'd0, pd}, {24'd0, exp_d});
    chk({tag, "_setup_rs"}, {31'd0, prs}, {31'd0, exp_rs});
    chk({tag, "_rw"}, {31'd0, lcd_if.lcd_rw}, 32'd0);
    hi = 0;
    while (lcd_if.lcd_e === 1'b1 && hi < 20) begin hi++; @(negedge clk); end
    chk({tag, "_e_width"}, hi, EP);
  endtask
  task automatic run_init(input string tag, output int raddr);
    int r0, r1, r2, r3, r4;
    r0 = cyc;
    wait_byte({tag, "_fset"}, 1'b0, 8'h38, r1);
    chk({tag, "_pwr_wait"}, r1 - r0, INIT + 1);
    wait_byte({tag, "_disp"}, 1'b0, 8'h0C, r2);
    chk({tag, "_fset_period"}, r2 - r1, PER);
    wait_byte({tag, "_clear"}, 1'b0, 8'h01, r3);
    chk({tag, "_disp_period"}, r3 - r2, PER);
    wait_byte({tag, "_entry"}, 1'b0, 8'h06, r4);
    chk({tag, "_clear_period"}, r4 - r3, PER_CLR);
    chk({tag, "_init_done_low"}, {31'd0, init_done}, 32'd0);
    wait_byte({tag, "_addr"}, 1'b0, 8'h80, raddr);
    chk({tag, "_entry_period"}, raddr - r4, PER);
    chk({tag, "_init_done_high"}, {31'd0, init_done}, 32'd1);
  endtask
  task automatic do_frame(input string tag, input logic [7:0] e [11], input int raddr, input int chg,
                          input logic [43:0] nd, output int rfirst, output int rlast);
    int r, rp;
    rp = raddr; rfirst = 0;
    for (int c = 0; c < 11; c++) begin
      wait_byte($sformatf("%s_col%0d", tag, c), 1'b1, e[c], r);
      chk($sformatf("%s_col%0d_period", tag, c), r - rp, PER);
      if (c == 0) rfirst = r;
      if (c == chg) num_data = nd;
      rp = r;
    end
    rlast = rp;
  endtask
  task automatic end_frame(input string tag, input int rfirst, input int rlast, input int base, output int raddr);
    wait_byte({tag, "_next_addr"}, 1'b0, 8'h80, raddr);
    chk({tag, "_addr_period"}, raddr - rlast, PER);
    chk({tag, "_frame_done_count"}, fd_total - base, 1);
    chk({tag, "_frame_done_cycle"}, fd_cyc, rfirst - 1 + 11 * PER);
    chk({tag, "_frame_done_at_setup"}, fd_cyc, raddr - 1);
  endtask
  initial begin
    int ra, rf, rl, base, n, r;
    logic found;
    num_data = D1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", {24'd0, lcd_if.lcd_data}, 32'h00);
    chk("rst_rs", {31'd0, lcd_if.lcd_rs}, 32'd0);
    chk("rst_rw", {31'd0, lcd_if.lcd_rw}, 32'd0);
    chk("rst_e", {31'd0, lcd_if.lcd_e}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    run_init("init1", ra);
    chk("no_early_frame_done", fd_total, 0);
    base = fd_total;
    do_frame("fr1", E1, ra, -1, D1, rf, rl);
    end_frame("fr1", rf, rl, base, ra);
    base = fd_total;
    do_frame("fr2", E1, ra, 4, D2, rf, rl);
    end_frame("fr2", rf, rl, base, ra);
    base = fd_total;
    do_frame("fr3", E2, ra, 4, D3, rf, rl);
    end_frame("fr3", rf, rl, base, ra);
    wait_byte("fr4_col0", 1'b1, E3[0], r);
    wait_byte("fr4_col1", 1'b1, E3[1], r);
    n = 0; found = 1'b0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (lcd_if.lcd_e === 1'b1) begin found = 1'b1; break; end
    end
    chk("fr4_col2_e_seen", {31'd0, found}, 32'd1);
    chk("fr4_col2_data", {24'd0, lcd_if.lcd_data}, {24'd0, E3[2]});
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_e", {31'd0, lcd_if.lcd_e}, 32'd0);
    chk("midrst_init_done", {31'd0, init_done}, 32'd0);
    chk("midrst_data", {24'd0, lcd_if.lcd_data}, 32'h00);
    chk("midrst_rs", {31'd0, lcd_if.lcd_rs}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_init("init2", ra);
    base = fd_total;
    do_frame("fr5", E3, ra, -1, D3, rf, rl);
    end_frame("fr5", rf, rl, base, ra);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
